cv32e40p_pc_redirect_unit: RTL

Parametrised successor of the core's fetch-address selection logic. Computes the redirect target from the PC mux selection, exception/trap selection and per-mode vector configuration, then registers it into a single-entry redirect holding buffer. The buffer presents the target to the prefetcher with a valid/ready handshake. A small FSM issues the boot redirect automatically after reset and generates the mtvec-init pulse to the CS register file. Sits between the controller/CSR file and the IF stage.

---
 rtl/cv32e40p_pc_redirect_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_pc_redirect_unit.sv
// PC redirect unit: selects the fetch redirect target and registers it into a
// single-entry holding buffer. The prefetcher takes the target through a
// valid/ready handshake. After reset the unit issues the boot redirect on its own.
module cv32e40p_pc_redirect_unit #(
    parameter int ADDR_WIDTH      = 32,
    parameter int TRAP_BASE_WIDTH = 24,
    parameter int NUM_TRAP_MODES  = 2
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       pc_set_i,
    input  logic [3:0]                                                 pc_mux_i,
    input  logic [2:0]                                                 exc_pc_mux_i,
    input  logic [$clog2(NUM_TRAP_MODES)-1:0]                          trap_addr_mux_i,
    input  logic [NUM_TRAP_MODES*TRAP_BASE_WIDTH-1:0]                  trap_base_addr_i,
    input  logic [NUM_TRAP_MODES*(ADDR_WIDTH-TRAP_BASE_WIDTH-3)-1:0]   exc_vec_idx_i,
    input  logic [NUM_TRAP_MODES-1:0]                                  trap_vectored_i,
    input  logic [ADDR_WIDTH-1:0]                                      boot_addr_i,
    input  logic [ADDR_WIDTH-1:0]                                      dm_halt_addr_i,
    input  logic [ADDR_WIDTH-1:0]                                      dm_exception_addr_i,
    input  logic [ADDR_WIDTH-1:0]                                      jump_target_id_i,
    input  logic [ADDR_WIDTH-1:0]                                      jump_target_ex_i,
    input  logic [ADDR_WIDTH-1:0]                                      mepc_i,
    input  logic [ADDR_WIDTH-1:0]                                      uepc_i,
    input  logic [ADDR_WIDTH-1:0]                                      depc_i,
    input  logic [ADDR_WIDTH-1:0]                                      pc_id_i,
    input  logic [ADDR_WIDTH-1:0]                                      hwlp_target_i,
    input  logic                                                       redirect_ready_i,
    output logic                                                       redirect_valid_o,
    output logic [ADDR_WIDTH-1:0]                                      redirect_addr_o,
    output logic [3:0]                                                 redirect_src_o,
    output logic                                                       redirect_overwrite_o,
    output logic                                                       csr_mtvec_init_o
);

    localparam int VEC_W  = ADDR_WIDTH - TRAP_BASE_WIDTH - 3;
    localparam int MODE_W = $clog2(NUM_TRAP_MODES);
    localparam int PAD_W  = ADDR_WIDTH - TRAP_BASE_WIDTH;

    localparam logic [3:0] PC_BOOT      = 4'd0;
    localparam logic [3:0] PC_FENCEI    = 4'd1;
    localparam logic [3:0] PC_JUMP      = 4'd2;
    localparam logic [3:0] PC_BRANCH    = 4'd3;
    localparam logic [3:0] PC_EXCEPTION = 4'd4;
    localparam logic [3:0] PC_MRET      = 4'd5;
    localparam logic [3:0] PC_URET      = 4'd6;
    localparam logic [3:0] PC_DRET      = 4'd7;
    localparam logic [3:0] PC_HWLOOP    = 4'd8;

    localparam logic [2:0] EXC_PC_EXCEPTION = 3'd0;
    localparam logic [2:0] EXC_PC_IRQ       = 3'd1;
    localparam logic [2:0] EXC_PC_DBD       = 3'd2;
    localparam logic [2:0] EXC_PC_DBE       = 3'd3;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_BOOT  = 2'd1,
        S_PEND  = 2'd2,
        S_IDLE  = 2'd3
    } state_t;

    state_t                  state_r, state_next_s;
    logic                    valid_r, valid_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_next_s;
    logic [3:0]              src_r, src_next_s;
    logic                    over_r, over_next_s;
    logic                    mtvec_r, mtvec_next_s;

    logic [TRAP_BASE_WIDTH-1:0] mode_base_s [NUM_TRAP_MODES];
    logic [VEC_W-1:0]           mode_idx_s  [NUM_TRAP_MODES];
    logic [MODE_W-1:0]          mode_sel_s;
    logic [TRAP_BASE_WIDTH-1:0] base_s;
    logic [VEC_W-1:0]           idx_s;
    logic                       vectored_s;
    logic [ADDR_WIDTH-1:0]      boot_aligned_s;
    logic [ADDR_WIDTH-1:0]      exc_pc_s;
    logic [ADDR_WIDTH-1:0]      target_s;

    // Split the packed per-mode trap configuration into one entry per mode.
    for (genvar g = 0; g < NUM_TRAP_MODES; g++) begin : g_mode
        assign mode_base_s[g] = trap_base_addr_i[g*TRAP_BASE_WIDTH +: TRAP_BASE_WIDTH];
        assign mode_idx_s[g]  = exc_vec_idx_i[g*VEC_W +: VEC_W];
    end

    assign boot_aligned_s = {boot_addr_i[ADDR_WIDTH-1:2], 2'b00};

    // Pick the trap mode; reserved mode codes fall back to machine mode.
    always_comb begin
        mode_sel_s = '0;
        if (int'(trap_addr_mux_i) < NUM_TRAP_MODES) begin
            mode_sel_s = trap_addr_mux_i;
        end else begin
            mode_sel_s = '0;
        end
        base_s     = mode_base_s[mode_sel_s];
        idx_s      = mode_idx_s[mode_sel_s];
        vectored_s = trap_vectored_i[mode_sel_s];
    end

    // Exception/interrupt/debug entry address.
    always_comb begin
        exc_pc_s = {base_s, {PAD_W{1'b0}}};
        case (exc_pc_mux_i)
            EXC_PC_EXCEPTION: exc_pc_s = {base_s, {PAD_W{1'b0}}};
            EXC_PC_IRQ: begin
                if (vectored_s) begin
                    exc_pc_s = {base_s, 1'b0, idx_s, 2'b00};
                end else begin
                    exc_pc_s = {base_s, {PAD_W{1'b0}}};
                end
            end
            EXC_PC_DBD:       exc_pc_s = {dm_halt_addr_i[ADDR_WIDTH-1:2], 2'b00};
            EXC_PC_DBE:       exc_pc_s = {dm_exception_addr_i[ADDR_WIDTH-1:2], 2'b00};
            default:          exc_pc_s = {base_s, {PAD_W{1'b0}}};
        endcase
    end

    // Redirect target for the requested PC source; unknown codes go to boot.
    always_comb begin
        target_s = boot_aligned_s;
        case (pc_mux_i)
            PC_BOOT:      target_s = boot_aligned_s;
            PC_FENCEI:    target_s = pc_id_i + ADDR_WIDTH'(4);
            PC_JUMP:      target_s = jump_target_id_i;
            PC_BRANCH:    target_s = jump_target_ex_i;
            PC_EXCEPTION: target_s = exc_pc_s;
            PC_MRET:      target_s = mepc_i;
            PC_URET:      target_s = uepc_i;
            PC_DRET:      target_s = depc_i;
            PC_HWLOOP:    target_s = hwlp_target_i;
            default:      target_s = boot_aligned_s;
        endcase
    end

    // Holding-buffer FSM: boot issue, capture, handshake and pulse generation.
    always_comb begin
        state_next_s = state_r;
        valid_next_s = valid_r;
        addr_next_s  = addr_r;
        src_next_s   = src_r;
        over_next_s  = 1'b0;
        mtvec_next_s = 1'b0;
        case (state_r)
            S_RESET: begin
                state_next_s = S_BOOT;
            end
            S_BOOT: begin
                state_next_s = S_PEND;
                valid_next_s = 1'b1;
                if (pc_set_i) begin
                    addr_next_s  = target_s;
                    src_next_s   = pc_mux_i;
                    mtvec_next_s = (pc_mux_i == PC_BOOT);
                end else begin
                    addr_next_s  = boot_aligned_s;
                    src_next_s   = PC_BOOT;
                    mtvec_next_s = 1'b1;
                end
            end
            S_PEND: begin
                if (pc_set_i) begin
                    // Latest request wins; it only counts as an overwrite
                    // if the old one was not taken this same cycle.
                    addr_next_s  = target_s;
                    src_next_s   = pc_mux_i;
                    over_next_s  = ~redirect_ready_i;
                    mtvec_next_s = (pc_mux_i == PC_BOOT);
                    state_next_s = S_PEND;
                end else if (redirect_ready_i) begin
                    valid_next_s = 1'b0;
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_PEND;
                end
            end
            S_IDLE: begin
                if (pc_set_i) begin
                    valid_next_s = 1'b1;
                    addr_next_s  = target_s;
                    src_next_s   = pc_mux_i;
                    mtvec_next_s = (pc_mux_i == PC_BOOT);
                    state_next_s = S_PEND;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: begin
                state_next_s = S_RESET;
                valid_next_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_RESET;
            valid_r <= 1'b0;
            addr_r  <= '0;
            src_r   <= 4'd0;
            over_r  <= 1'b0;
            mtvec_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            valid_r <= valid_next_s;
            addr_r  <= addr_next_s;
            src_r   <= src_next_s;
            over_r  <= over_next_s;
            mtvec_r <= mtvec_next_s;
        end
    end

    assign redirect_valid_o     = valid_r;
    assign redirect_addr_o      = addr_r;
    assign redirect_src_o       = src_r;
    assign redirect_overwrite_o = over_r;
    assign csr_mtvec_init_o     = mtvec_r;

endmodule
